// File: rtl/sync_fifo_wm.sv
// Single-clock FIFO with programmable almost_full/almost_empty watermarks, occupancy count
// and sticky overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_wm #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  half_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  half_empty,
  output logic [AW:0]           count,
  input  logic [AW:0]           af_thresh,
  input  logic [AW:0]           ae_thresh,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_wm: DEPTH must be a power of two and at least 4");
    end
  endgenerate

  localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Extra pointer MSB distinguishes a full buffer from an empty one at equal indices.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign empty = (wr_ptr == rd_ptr);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign almost_full  = (af_thresh != '0) && (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);
  assign half_full    = (count >= HALF_CNT);
  assign half_empty   = ~half_full;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      // A fresh error in the same cycle as clr_err keeps the flag set.
      overflow  <= (overflow  & ~clr_err) | (wr_en & full);
      underflow <= (underflow & ~clr_err) | (rd_en & empty);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = mem[rd_idx];
  assign rd_valid = ~empty;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_wm.sv
// Directed self-checking bench for sync_fifo_wm (DEPTH=16, DATA_WIDTH=8); follows SYNC_FIFO_FWFT_EN
// when it is defined for the build.
module tb_sync_fifo_wm;

  localparam int DW = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          almost_full;
  logic          half_full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          almost_empty;
  logic          half_empty;
  logic [AW:0]   count;
  logic [AW:0]   af_thresh;
  logic [AW:0]   ae_thresh;
  logic          overflow;
  logic          underflow;
  logic          clr_err;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_q[$];

  always #5 clk = ~clk;

  sync_fifo_wm #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full), .half_full(half_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .half_empty(half_empty),
    .count(count), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic clr);
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    clr_err = clr;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic popCheck(input logic wr, input logic [DW-1:0] wd, input logic [DW-1:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    checkOutput("fwft_valid", 32'(rd_valid), 32'd1);
    checkOutput("fwft_data", 32'(rd_data), 32'(exp));
    applyStimulus(wr, wd, 1'b1, 1'b0);
`else
    applyStimulus(wr, wd, 1'b1, 1'b0);
    checkOutput("rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd_data", 32'(rd_data), 32'(exp));
`endif
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
    af_thresh = 5'd12; ae_thresh = 5'd3;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("rst_half_empty", 32'(half_empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_half_full", 32'(half_full), 32'd0);
    checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
    checkOutput("rst_errors", 32'({overflow, underflow}), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
`endif

    // Fill 0x00..0x0F and watch the flags climb.
    for (int i = 0; i < D; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("fill_count", 32'(count), 32'(i + 1));
      checkOutput("fill_half_full", 32'(half_full), 32'((i + 1) >= 8));
      checkOutput("fill_almost_full", 32'(almost_full), 32'((i + 1) >= 12));
      checkOutput("fill_full", 32'(full), 32'((i + 1) == 16));
    end
    checkOutput("fill_overflow", 32'(overflow), 32'd0);

    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("ovf_count", 32'(count), 32'd16);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);

    for (int i = 0; i < D; i++) begin
      popCheck(1'b0, 8'h00, 8'(i));
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_half_empty", 32'(half_empty), 32'd1);
    checkOutput("drain_ovf_sticky", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_overflow", 32'(overflow), 32'd0);
    checkOutput("idle_rd_valid", 32'(rd_valid), 32'd0);

    // Underflow, clearing, and error-beats-clear.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("udf_flag", 32'(underflow), 32'd1);
    checkOutput("udf_rd_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("udf_clear", 32'(underflow), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("udf_wins_clear", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous write+read while full.
    for (int i = 0; i < D; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    popCheck(1'b1, 8'hBB, 8'h10);
    checkOutput("simfull_count", 32'(count), 32'd15);
    checkOutput("simfull_overflow", 32'(overflow), 32'd1);
    for (int i = 1; i < D; i++) popCheck(1'b0, 8'h00, 8'(8'h10 + i));
    checkOutput("simfull_drained", 32'(empty), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous write+read while empty.
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("simempty_count", 32'(count), 32'd1);
    checkOutput("simempty_underflow", 32'(underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    checkOutput("simempty_rd_valid", 32'(rd_valid), 32'd0);
`endif
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h78 + i), 1'b0, 1'b0);
    checkOutput("sim5_pre_count", 32'(count), 32'd5);
    popCheck(1'b1, 8'h7C, 8'h77);
    checkOutput("sim5_count", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) popCheck(1'b0, 8'h00, 8'(8'h78 + i));
    checkOutput("sim5_empty", 32'(empty), 32'd1);

    // Interleaved traffic across pointer wrap, checked against a queue model.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      model_q.push_back(8'(8'h60 + i));
    end
    for (int k = 0; k < 40; k++) begin
      logic do_wr;
      logic do_rd;
      logic [DW-1:0] wd;
      do_wr = (k < 20) ? 1'b1 : (k % 2 == 0);
      do_rd = (k < 20) ? (k % 2 == 1) : 1'b1;
      wd    = 8'(8'h80 + k);
      if (do_rd) begin
        popCheck(do_wr, wd, model_q[0]);
        void'(model_q.pop_front());
      end else begin
        applyStimulus(do_wr, wd, 1'b0, 1'b0);
      end
      if (do_wr) model_q.push_back(wd);
      checkOutput("wrap_count", 32'(count), 32'(model_q.size()));
      checkOutput("wrap_almost_empty", 32'(almost_empty), 32'(model_q.size() <= 3));
    end
    while (model_q.size() > 0) begin
      popCheck(1'b0, 8'h00, model_q[0]);
      void'(model_q.pop_front());
    end
    checkOutput("wrap_empty", 32'(empty), 32'd1);

    // Reset in the middle of operation.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    checkOutput("mid_pre_count", 32'(count), 32'd9);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("mid_count", 32'(count), 32'd0);
    checkOutput("mid_empty", 32'(empty), 32'd1);
    checkOutput("mid_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("mid_errors", 32'({overflow, underflow}), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    checkOutput("mid_rd_data", 32'(rd_data), 32'd0);
`endif
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    popCheck(1'b0, 8'h00, 8'h5A);
    checkOutput("mid_final_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_wm.md
Name: sync_fifo_wm

Overview:
Single-clock, parametrised successor to the team's async FIFO for same-domain buffering between pipeline stages.
- Keeps the half_full / half_empty status set.
- Adds runtime-programmable almost_full / almost_empty watermarks, an occupancy count and sticky overflow/underflow error flags.
- Optional first-word-fall-through read mode.
- Used wherever producer and consumer share one clock, so no gray-code synchronisers are needed.

Parameters:
- DATA_WIDTH, 32, width of wr_data / rd_data in bits.
- DEPTH, 256, number of entries; must be a power of two, >= 4; elaboration error otherwise.
- AW (localparam), $clog2(DEPTH), pointer index width; count and thresholds are AW+1 bits.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write data.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= af_thresh (forced 0 when af_thresh == 0).
- half_full  output  1  count >= DEPTH/2.
- rd_en  input  1  read request (pop acknowledge in FWFT mode).
- rd_data  output  DATA_WIDTH  read data.
- rd_valid  output  1  rd_data qualifier.
- empty  output  1  count == 0.
- almost_empty  output  1  count <= ae_thresh.
- half_empty  output  1  count < DEPTH/2.
- count  output  AW+1  current occupancy, 0..DEPTH.
- af_thresh  input  AW+1  almost-full watermark, quasi-static.
- ae_thresh  input  AW+1  almost-empty watermark, quasi-static.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.
- clr_err  input  1  clears overflow/underflow.

Behaviour:
- Reset (rst=1 at clk edge): pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Resulting flags: empty=1, almost_empty=1, half_empty=1, full=0, half_full=0, almost_full=0 (unless 0 >= af_thresh != 0, impossible).
  - Memory contents not cleared.
  - Reset mid-operation discards all entries; the next cycle behaves as post-reset.
- Pointers:
  - wr_ptr and rd_ptr are AW+1 bits, binary, wrapping naturally at 2*DEPTH.
  - Index = low AW bits.
  - full when MSBs differ and low bits are equal; empty when pointers are equal.
- Handshake:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - full/empty are the registered-state values from before the edge.
  - A rejected write has no effect on state; it sets overflow. A rejected read sets underflow.
- Simultaneous write and read:
  - Both accepted: count unchanged, both pointers advance.
  - At full: read accepted, write rejected, overflow set, count = DEPTH-1.
  - At empty: write accepted, read rejected, underflow set, count = 1.
- count: +1 on wr_acc only, -1 on rd_acc only, registered.
- Flags: all status flags are combinational decodes of registered count/pointers. A write becomes visible in the flags the cycle after its edge.
- Standard read mode:
  - On rd_acc, rd_data <= mem[rd_idx] at the edge and rd_valid=1 for exactly the following cycle.
  - rd_data holds its value otherwise; rd_valid=0 otherwise.
  - Read latency is 1 cycle.
- Error flags:
  - clr_err clears both sticky flags.
  - A new error event in the same cycle as clr_err wins (flag stays 1).
- Watermarks:
  - Thresholds are compared unsigned.
  - af_thresh > DEPTH means almost_full is never asserted.
  - ae_thresh >= DEPTH means almost_empty is always asserted.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - rd_data = mem[rd_idx] combinationally and rd_valid = ~empty.
  - rd_en acts as pop acknowledge: the head is removed at the edge when rd_acc.
  - The first written word appears on rd_data the cycle after its write edge.
  - rd_data is undefined while empty.
- Undefined: standard registered read behaviour as above.

Test Plan:
All tests use DEPTH=16, DATA_WIDTH=8.
- Reset then fill: write 0x00..0x0F on 16 consecutive cycles -> count=16, full=1, half_full=1 from count 8, almost_full=1 from count 12 (af_thresh=12), overflow=0.
- Overflow: at full, assert wr_en with 0xAA -> count stays 16, overflow=1; contents unchanged. Drain 16 reads -> rd_data 0x00..0x0F in order, one cycle after each rd_en, then empty=1, half_empty=1.
- Underflow and clear: rd_en while empty -> underflow=1, rd_valid=0. Assert clr_err -> underflow=0 next cycle. clr_err and rd_en at empty in the same cycle -> underflow stays 1.
- Simultaneous: at count=16, wr_en & rd_en -> count=15, overflow=1. At count=0, wr_en & rd_en -> count=1, underflow=1. At count=5, both -> count=5, data order preserved.
- Wrap-around: 40 cycles of interleaved writes/reads keeping count 3..14 -> pointers wrap past 32, output sequence matches written sequence exactly. With ae_thresh=3, almost_empty=1 only when count<=3.
- Reset mid-operation: at count=9 assert rst one cycle -> count=0, empty=1, rd_valid=0, rd_data=0, errors cleared. Then write 0x5A and read it -> rd_data=0x5A. With SYNC_FIFO_FWFT_EN, 0x5A appears the cycle after the write with rd_valid=1 before rd_en.
